// File: rtl/deserializer.sv
// I2S ADC deserializer: synchronizes BCLK/ADCLRCK/ADCDAT into CLOCK_50 and captures signed left/right samples.
// Optional mono down-mix when DESERIALIZER_MONO_EN is defined.
module deserializer #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET,
    input  logic                         BCLK,
    input  logic                         ADCLRCK,
    input  logic                         ADCDAT,
    output logic signed [DATA_WIDTH-1:0] leftSample,
    output logic signed [DATA_WIDTH-1:0] rightSample,
    output logic                         sampleValid,
    output logic                         frameError
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        WAIT_SYNC,
        LEFT,
        RIGHT
    } state_t;

    logic [SYNC_STAGES-1:0]        bclk_sync;
    logic [SYNC_STAGES-1:0]        lrck_sync;
    logic [SYNC_STAGES-1:0]        dat_sync;
    logic                          bclk_s;
    logic                          lrck_s;
    logic                          dat_s;
    logic                          bclk_prev_p0;
    logic                          lrck_prev_p0;
    logic                          bit_evt;
    logic                          boundary;
    state_t                        state;
    logic [CNT_W-1:0]              bit_cnt;
    logic signed [DATA_WIDTH-1:0]  shift_reg;
    logic signed [DATA_WIDTH-1:0]  left_hold;
    logic                          vld_p0;

`ifdef DESERIALIZER_MONO_EN
    // Average of the two channels; the extra sum bit keeps the add from overflowing.
    function automatic logic signed [DATA_WIDTH-1:0] mono_mix(
        input logic signed [DATA_WIDTH-1:0] l,
        input logic signed [DATA_WIDTH-1:0] r
    );
        logic signed [DATA_WIDTH:0] sum;
        sum = $signed({l[DATA_WIDTH-1], l}) + $signed({r[DATA_WIDTH-1], r});
        return sum[DATA_WIDTH:1];
    endfunction
`endif

    assign bclk_s   = bclk_sync[SYNC_STAGES-1];
    assign lrck_s   = lrck_sync[SYNC_STAGES-1];
    assign dat_s    = dat_sync[SYNC_STAGES-1];
    assign bit_evt  = bclk_s & ~bclk_prev_p0;
    assign boundary = lrck_s ^ lrck_prev_p0;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            bclk_sync    <= '0;
            lrck_sync    <= '0;
            dat_sync     <= '0;
            bclk_prev_p0 <= 1'b0;
            lrck_prev_p0 <= 1'b0;
            state        <= WAIT_SYNC;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            left_hold    <= '0;
            vld_p0       <= 1'b0;
            leftSample   <= '0;
            rightSample  <= '0;
            sampleValid  <= 1'b0;
            frameError   <= 1'b0;
        end else begin
            // All three lines share one synchronizer depth so they stay aligned
            bclk_sync    <= {bclk_sync[SYNC_STAGES-2:0], BCLK};
            lrck_sync    <= {lrck_sync[SYNC_STAGES-2:0], ADCLRCK};
            dat_sync     <= {dat_sync[SYNC_STAGES-2:0], ADCDAT};
            bclk_prev_p0 <= bclk_s;
            frameError   <= 1'b0;
            vld_p0       <= 1'b0;

            if (bit_evt) begin
                lrck_prev_p0 <= lrck_s;
                unique case (state)
                    WAIT_SYNC: begin
                        if (boundary && !lrck_s) begin
                            bit_cnt <= '0;
                            state   <= LEFT;
                        end
                    end
                    LEFT: begin
                        if (boundary) begin
                            if (bit_cnt == CNT_FULL) begin
                                left_hold <= shift_reg;
                                bit_cnt   <= '0;
                                state     <= RIGHT;
                            end else begin
                                frameError <= 1'b1;
                                state      <= WAIT_SYNC;
                            end
                        end else if (bit_cnt != CNT_FULL) begin
                            shift_reg <= {shift_reg[DATA_WIDTH-2:0], dat_s};
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end
                    RIGHT: begin
                        if (boundary) begin
                            frameError <= (bit_cnt != CNT_FULL);
                            bit_cnt    <= '0;
                            state      <= LEFT;
                        end else if (bit_cnt != CNT_FULL) begin
                            shift_reg <= {shift_reg[DATA_WIDTH-2:0], dat_s};
                            bit_cnt   <= bit_cnt + 1'b1;
                            vld_p0    <= (bit_cnt == CNT_LAST);
                        end
                    end
                    default: state <= WAIT_SYNC;
                endcase
            end

            // Output stage: one cycle after the last right bit lands in shift_reg
            sampleValid <= vld_p0;
            if (vld_p0) begin
`ifdef DESERIALIZER_MONO_EN
                leftSample  <= mono_mix(left_hold, shift_reg);
                rightSample <= mono_mix(left_hold, shift_reg);
`else
                leftSample  <= left_hold;
                rightSample <= shift_reg;
`endif
            end
        end
    end

endmodule
